// File: rtl/serial_pkg.sv
// Shared constants for the serial transmit arbiter: FSM state encodings,
// default requester count and inter-frame gap, and an index-width helper.
package serial_pkg;

    // Default number of byte requesters and idle cycles between frames.
    localparam int DEFAULT_PORTS = 4;
    localparam int DEFAULT_GAP   = 4;

    // FSM encoding kept as plain constants so legacy tools can use it.
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] S_WAIT  = 2'd2;
    localparam logic [STATE_W-1:0] S_GAP   = 2'd3;

    // Width of a port index; at least one bit, even for tiny port counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : serial_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. Searches upward from the port after
// last_i, wrapping around, and returns the first requesting port both as a
// one-hot vector and as an index. Returns all-zero when nothing requests.
module rr_arbiter
    import serial_pkg::*;
#(
    parameter  int PORTS = DEFAULT_PORTS,
    localparam int IDX_W = idx_width(PORTS)
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic found;

    // Walk the search offsets 1..PORTS and take the first requesting port.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int off = 1; off <= PORTS; off++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (!found && req_i[p] && (p == ((int'(last_i) + off) % PORTS))) begin
                    found     = 1'b1;
                    gnt_o[p]  = 1'b1;
                    gnt_idx_o = IDX_W'(p);
                end
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from several requesters into one
// serial transmitter. One frame at a time: accept a byte, pulse the
// transmitter for one cycle, wait for it to finish, idle for GAP cycles,
// then arbitrate again. The transmitter itself lives outside this block.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int PORTS = DEFAULT_PORTS,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic               clk_x4,
    input  logic               rst_x,
    input  logic [8*PORTS-1:0] i_req_data,
    input  logic [PORTS-1:0]   i_req_valid,
    output logic [PORTS-1:0]   o_req_ready,
    output logic [PORTS-1:0]   o_grant,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_busy,
    input  logic               i_tx_error,
    output logic               o_error
);

    localparam int          IDX_W    = idx_width(PORTS);
    localparam logic [7:0]  GAP_LOAD = 8'(GAP);

    // Registered state and its next-state values.
    logic [STATE_W-1:0] state_q,      state_d;
    logic [IDX_W-1:0]   last_q,       last_d;
    logic [PORTS-1:0]   grant_q,      grant_d;
    logic [7:0]         tx_data_q,    tx_data_d;
    logic [7:0]         gap_cnt_q,    gap_cnt_d;
    logic               wait_first_q, wait_first_d;
    logic               error_q,      error_d;

    // Arbiter results and the byte offered by the winning port.
    logic [PORTS-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [7:0]         sel_byte;
    logic               handshake;

    rr_arbiter #(
        .PORTS (PORTS)
    ) u_rr_arbiter (
        .req_i     (i_req_valid),
        .last_i    (last_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    // Ready only in idle with the transmitter free; also held low while the
    // reset is asserted so nothing is accepted in the cycle being reset.
    assign o_req_ready = (state_q == S_IDLE && !i_tx_busy && rst_x) ? arb_gnt : '0;

    // The arbiter only picks valid ports, so any ready bit is a handshake.
    assign handshake = |o_req_ready;

    // Pick the winning port's byte out of the packed request bus.
    always_comb begin
        sel_byte = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (arb_gnt[p]) begin
                sel_byte = i_req_data[8*p +: 8];
            end
        end
    end

    // Frame sequencing: idle -> issue (one cycle) -> wait for the transmitter
    // to go quiet -> optional gap -> idle.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_d      = grant_q;
        tx_data_d    = tx_data_q;
        gap_cnt_d    = gap_cnt_q;
        wait_first_d = wait_first_q;
        error_d      = error_q | i_tx_error;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d   = S_ISSUE;
                    last_d    = arb_idx;
                    grant_d   = arb_gnt;
                    tx_data_d = sel_byte;
                end
            end

            S_ISSUE: begin
                // The transmitter only reports busy from the cycle after the
                // start pulse, so the first wait cycle must not sample it.
                state_d      = S_WAIT;
                wait_first_d = 1'b1;
            end

            S_WAIT: begin
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!i_tx_busy) begin
                    grant_d = '0;
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_GAP: begin
                // Counter holds the remaining gap cycles including this one.
                if (gap_cnt_q <= 8'd1) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = 8'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any frame in flight and makes port 0
    // the first candidate by pointing last at the highest port.
    always_ff @(posedge clk_x4) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!rst_x) begin
            state_q      <= S_IDLE;
            last_q       <= IDX_W'(PORTS - 1);
            grant_q      <= '0;
            tx_data_q    <= 8'd0;
            gap_cnt_q    <= 8'd0;
            wait_first_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            tx_data_q    <= tx_data_d;
            gap_cnt_q    <= gap_cnt_d;
            wait_first_q <= wait_first_d;
            error_q      <= error_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = (state_q == S_ISSUE);
    assign o_error    = error_q;

endmodule : serial_tx_arbiter
